program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter BASE_ADDR, default 8'h00: first memory address written.
REQ-002 Parameter LOAD_LEN, default 255: bytes per load, legal range 1..255.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-high.
REQ-005 start  input  1: single-cycle pulse; begins a load when IDLE or DONE.
REQ-006 abort  input  1: terminates a load in progress.
REQ-007 in_valid  input  1: source presents in_data.
REQ-008 in_data  input  8: byte to load.
REQ-009 in_ready  output  1: loader accepts a byte this cycle.
REQ-010 addr  output  8: memory address.
REQ-011 ie  output  1: memory write enable; the memory latches bus on falling clk while ie=1.
REQ-012 bus  inout  8: shared system bus; driven only while writing, else 8'bzzzzzzzz.
REQ-013 cpu_hold  output  1: holds the CPU off the bus and halted while loading.
REQ-014 busy  output  1: load in progress.
REQ-015 done  output  1: last load completed normally; sticky.
REQ-016 overflow  output  1: load stopped because addr would pass 8'hFE; sticky.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, WRITE, DONE; encoding is free.
REQ-018 IDLE/DONE + start=1 -> WAIT; addr<=BASE_ADDR, count<=0, done<=0, overflow<=0.
REQ-019 start in WAIT or WRITE SHALL be ignored.
REQ-020 in_ready SHALL be 1 only in state WAIT (combinational from state).
REQ-021 WAIT + in_valid=1 at a rising edge: capture in_data into data register, -> WRITE.
REQ-022 WRITE lasts exactly one cycle: ie=1, bus=data register, addr stable throughout.
REQ-023 ie and bus-enable SHALL be register outputs; no glitches, no 1 outside WRITE.
REQ-024 Leaving WRITE: count<=count+1; if count+1==LOAD_LEN -> DONE, done<=1; else if addr==8'hFE -> DONE, overflow<=1; else addr<=addr+1, -> WAIT.
REQ-025 Throughput: one byte per 2 cycles with in_valid held high; first in_ready 1 cycle after start.
REQ-026 in_valid outside WAIT SHALL be ignored; no byte is stored or lost-counted.
REQ-027 addr SHALL never exceed 8'hFE; no wrap to 8'h00.
REQ-028 busy=cpu_hold=1 in WAIT and WRITE, 0 in IDLE and DONE.
REQ-029 abort in WAIT or WRITE -> IDLE next edge; done=0, overflow unchanged; a WRITE cycle in progress completes its memory write, ie deasserts at the edge.
REQ-030 abort and start in the same cycle: abort wins.
REQ-031 DONE holds done/overflow until next start or rst; addr holds last written address.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, addr=0, count=0, data=0, ie=0, bus=Z, in_ready=0, cpu_hold=0, busy=0, done=0, overflow=0.
REQ-033 rst mid-load SHALL abandon the load; bytes already written remain in memory.
REQ-034 Release of rst SHALL produce no ie pulse and no bus drive.

Verification
REQ-035 LOAD_LEN=4, BASE=0; start, stream 11,22,33,44 with in_valid high -> mem[0..3]=11,22,33,44; done=1 at cycle 9 after start; ie pulsed 4 times.
REQ-036 in_valid toggled randomly; bytes A0..A7, LOAD_LEN=8 -> mem[0..7]=A0..A7 in order; in_ready never 1 outside WAIT.
REQ-037 BASE=8'hFC, LOAD_LEN=10 -> writes FC,FD,FE only; overflow=1, done=0; addr=FE.
REQ-038 abort during the 3rd WRITE cycle -> 3 bytes written, state IDLE, busy=0, bus Z next cycle.
REQ-039 rst asserted mid-WRITE, asynchronously -> ie=0 and bus Z without waiting for clk; start after release restarts at BASE.
REQ-040 start while busy plus start and abort simultaneous -> no restart, IDLE respectively; bus never driven with ie=0.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: streams LOAD_LEN bytes into memory from BASE_ADDR, holding the CPU off the bus while loading
module program_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int LOAD_LEN = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] addr,
  output logic       ie,
  inout  wire  [7:0] bus,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;
  state_t state, next;
  logic [7:0] count, data, cnt_inc;
  logic last;
  assign cnt_inc = count + 8'd1;
  assign last = cnt_inc == 8'(LOAD_LEN);
  assign busy = state == WAIT || state == WRITE;
  assign cpu_hold = busy;
  assign in_ready = state == WAIT;
  // ie doubles as the bus enable, so the bus is only ever driven by a register
  assign bus = ie ? data : 8'bz;
  always_comb begin
    next = state;
    if (abort)
      next = busy ? IDLE : state;
    else if (start && !busy)
      next = WAIT;
    else if (state == WAIT && in_valid)
      next = WRITE;
    else if (state == WRITE)
      next = (last || addr == 8'hFE) ? DONE : WAIT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr <= 8'h00;
      count <= 8'h00;
      data <= 8'h00;
      ie <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= next;
      ie <= next == WRITE;
      if (!busy && next == WAIT) begin
        addr <= BASE_ADDR;
        count <= 8'h00;
        done <= 1'b0;
        overflow <= 1'b0;
      end
      if (state == WAIT && next == WRITE)
        data <= in_data;
      // done takes precedence over overflow when the last byte lands on 8'hFE
      if (state == WRITE && !abort) begin
        count <= cnt_inc;
        if (last)
          done <= 1'b1;
        else if (addr == 8'hFE)
          overflow <= 1'b1;
        else
          addr <= addr + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed checks of program_loader in three parameterisations sharing one clock
module tb_program_loader;
  logic clk = 0, rst = 1;
  logic [2:0] start = 0, abort = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic [2:0] in_ready, ie, cpu_hold, busy, done, overflow;
  logic [7:0] addr [3];
  wire [7:0] bus0, bus1, bus2;
  logic [7:0] mem0 [256], mem1 [256], mem2 [256];
  int pulses [3];
  int bad_ready = 0, checks = 0, failures = 0, k, p;
  logic v;
  logic [7:0] t1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] t4 [4] = '{8'h55, 8'h66, 8'h77, 8'h88};

  program_loader #(.BASE_ADDR(8'h00), .LOAD_LEN(4)) u0 (.clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .in_valid(in_valid[0]), .in_data(in_data), .in_ready(in_ready[0]), .addr(addr[0]), .ie(ie[0]), .bus(bus0),
    .cpu_hold(cpu_hold[0]), .busy(busy[0]), .done(done[0]), .overflow(overflow[0]));
  program_loader #(.BASE_ADDR(8'h00), .LOAD_LEN(8)) u1 (.clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .in_valid(in_valid[1]), .in_data(in_data), .in_ready(in_ready[1]), .addr(addr[1]), .ie(ie[1]), .bus(bus1),
    .cpu_hold(cpu_hold[1]), .busy(busy[1]), .done(done[1]), .overflow(overflow[1]));
  program_loader #(.BASE_ADDR(8'hFC), .LOAD_LEN(10)) u2 (.clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]),
    .in_valid(in_valid[2]), .in_data(in_data), .in_ready(in_ready[2]), .addr(addr[2]), .ie(ie[2]), .bus(bus2),
    .cpu_hold(cpu_hold[2]), .busy(busy[2]), .done(done[2]), .overflow(overflow[2]));

  always #5 clk = ~clk;

  // memory model: latches the bus on the falling edge while ie is high
  always @(negedge clk) begin
    if (ie[0]) begin mem0[addr[0]] = bus0; pulses[0]++; end
    if (ie[1]) begin mem1[addr[1]] = bus1; pulses[1]++; end
    if (ie[2]) begin mem2[addr[2]] = bus2; pulses[2]++; end
    for (int i = 0; i < 3; i++)
      if (in_ready[i] && (ie[i] || !busy[i])) bad_ready++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem0[i] = 0; mem1[i] = 0; mem2[i] = 0; end
    for (int i = 0; i < 3; i++) pulses[i] = 0;
    step; step;
    chk("rst_busy", {29'd0, busy}, 0);
    chk("rst_hold", {29'd0, cpu_hold}, 0);
    chk("rst_ready", {29'd0, in_ready}, 0);
    chk("rst_ie", {29'd0, ie}, 0);
    chk("rst_flags", {26'd0, done, overflow}, 0);
    chk("rst_addr", addr[2], 0);
    rst = 0;
    step; step;
    chk("rel_ie", {29'd0, ie}, 0);
    // four bytes streamed back to back: done appears on the ninth edge after start
    start[0] = 1; in_valid[0] = 1; in_data = t1[0]; p = pulses[0];
    step;
    start[0] = 0;
    chk("t1_ready", in_ready[0], 1);
    chk("t1_busy", {30'd0, busy[0], cpu_hold[0]}, 3);
    for (int i = 2; i <= 9; i++) begin
      step;
      if (i % 2 == 0) begin
        chk("t1_ie", ie[0], 1);
        chk("t1_addr", addr[0], i / 2 - 1);
        chk("t1_bus", bus0, t1[i / 2 - 1]);
        if (i < 8) in_data = t1[i / 2];
      end else if (i < 9) chk("t1_wait", in_ready[0], 1);
      chk("t1_done", done[0], i == 9);
    end
    chk("t1_idle", {30'd0, busy[0], ie[0]}, 0);
    chk("t1_pulses", pulses[0] - p, 4);
    for (int j = 0; j < 4; j++) chk("t1_mem", mem0[j], t1[j]);
    step; step;
    chk("t1_hold_done", done[0], 1);
    chk("t1_hold_addr", addr[0], 3);
    in_valid[0] = 0;
    // eight bytes with in_valid toggled randomly; junk data whenever not ready
    start[1] = 1;
    step;
    start[1] = 0; k = 0;
    for (int c = 0; c < 300 && !done[1]; c++) begin
      in_valid[1] = 1'($urandom_range(0, 1));
      in_data = in_ready[1] ? 8'(8'hA0 + k) : 8'hEE;
      v = in_valid[1] && in_ready[1];
      step;
      if (v) k++;
    end
    in_valid[1] = 0;
    chk("t2_done", done[1], 1);
    chk("t2_count", k, 8);
    for (int j = 0; j < 8; j++) chk("t2_mem", mem1[j], 8'hA0 + j);
    chk("t2_ready_outside_wait", bad_ready, 0);
    // base FC with length 10 must stop after FE
    start[2] = 1; in_valid[2] = 1; k = 0;
    step;
    start[2] = 0;
    for (int c = 0; c < 50 && busy[2]; c++) begin
      in_data = 8'(8'hC0 + k);
      v = in_ready[2];
      step;
      if (v) k++;
    end
    in_valid[2] = 0;
    chk("t3_overflow", overflow[2], 1);
    chk("t3_done", done[2], 0);
    chk("t3_addr", addr[2], 8'hFE);
    chk("t3_pulses", pulses[2], 3);
    for (int j = 0; j < 3; j++) chk("t3_mem", mem2[8'hFC + j], 8'hC0 + j);
    // abort during the third write cycle
    start[0] = 1; in_valid[0] = 1; in_data = t4[0];
    step;
    start[0] = 0;
    for (int i = 2; i <= 6; i++) begin
      step;
      if (i % 2 == 0) in_data = t4[i / 2];
    end
    chk("t4_ie", ie[0], 1);
    abort[0] = 1;
    step;
    abort[0] = 0; in_valid[0] = 0;
    chk("t4_idle", {27'd0, busy[0], cpu_hold[0], ie[0], in_ready[0], done[0]}, 0);
    chk("t4_bus_released", bus0 === 8'h77, 0);
    step;
    chk("t4_stay", busy[0], 0);
    for (int j = 0; j < 3; j++) chk("t4_mem", mem0[j], t4[j]);
    chk("t4_mem3", mem0[3], 8'h44);
    // asynchronous reset in the middle of a write
    start[0] = 1; in_valid[0] = 1; in_data = 8'h99;
    step;
    start[0] = 0;
    step;
    chk("t5_ie", ie[0], 1);
    #1 rst = 1;
    #1;
    chk("t5_async", {26'd0, ie[0], busy[0], in_ready[0], done[0], overflow[0], overflow[2]}, 0);
    chk("t5_addr", addr[0], 0);
    chk("t5_bus_released", bus0 === 8'h99, 0);
    #1 rst = 0;
    step;
    chk("t5_rel_ie", ie[0], 0);
    chk("t5_mem_kept", mem0[0], 8'h55);
    in_data = 8'h9A; start[0] = 1;
    step;
    start[0] = 0;
    step;
    chk("t5_restart", {ie[0], addr[0]}, {1'b1, 8'h00});
    chk("t5_bus", bus0, 8'h9A);
    step;
    abort[0] = 1;
    step;
    abort[0] = 0; in_valid[0] = 0;
    chk("t5_abort", busy[0], 0);
    // start while busy is ignored; abort beats a simultaneous start
    in_valid[0] = 1; in_data = 8'h10; start[0] = 1;
    step;
    start[0] = 0;
    step;
    start[0] = 1; in_data = 8'h20;
    step;
    chk("t6_no_restart", {busy[0], addr[0]}, {1'b1, 8'h01});
    step;
    chk("t6_write", {ie[0], addr[0]}, {1'b1, 8'h01});
    chk("t6_bus", bus0, 8'h20);
    start[0] = 0;
    step;
    start[0] = 1; abort[0] = 1;
    step;
    chk("t6_abort_wins", {29'd0, busy[0], in_ready[0], ie[0]}, 0);
    step;
    chk("t6_idle_abort_wins", {30'd0, busy[0], in_ready[0]}, 0);
    start[0] = 0; abort[0] = 0; in_valid[0] = 0;
    step;
    chk("t6_final", busy[0], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
